riscv_id_ex_reg: RTL and testbench
==================================

// Module: riscv_id_ex_reg
// PURPOSE
//  ID/EX pipeline register: sits directly downstream of the instruction decoder and captures its control bundle plus operands, imm, PC and register addresses for EX.
//  Owns load-use hazard detection: inserts one bubble into EX and holds IF/ID and the PC for one cycle.
//  Honours a downstream stall (hold) and a taken-branch flush (bubble). Latency 1 cycle.
// PARAMETERS
//  XLEN    32  datapath width (pc, rs data, imm)
//  PERF_W  32  width of the optional perf counters
// PORTS
//  clk              in   1     clock, rising edge
//  rst              in   1     asynchronous reset, active-high
//  id_valid_i       in   1     ID holds a real instruction
//  id_pc_i          in   XLEN  PC of the ID instruction
//  id_rs1_addr_i    in   5     source reg 1 index
//  id_rs2_addr_i    in   5     source reg 2 index
//  id_rd_addr_i     in   5     destination reg index
//  id_rs1_used_i    in   1     instruction reads rs1 (gates hazard compare)
//  id_rs2_used_i    in   1     instruction reads rs2 (gates hazard compare)
//  id_rs1_data_i    in   XLEN  regfile read data 1
//  id_rs2_data_i    in   XLEN  regfile read data 2
//  id_imm_i         in   XLEN  extended immediate
//  id_ctrl_i        in   16    {RegWr,BranchOp[2:0],MemtoReg,MemWr,MemOp[2:0],ALUAsrc,ALUBsrc[1:0],ALUctr[3:0]}
//  ex_stall_i       in   1     EX/MEM cannot accept; hold ID/EX
//  flush_i          in   1     taken branch/jump in EX; kill the ID instruction
//  id_stall_o       out  1     hold PC and IF/ID this cycle (combinational)
//  ex_valid_o       out  1     EX holds a real instruction
//  ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  XLEN each  registered copies
//  ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o       out  5 each     registered copies (forwarding unit)
//  ex_ctrl_o        out  16    registered control bundle, same layout as id_ctrl_i
// BEHAVIOUR
//  - Reset (async, any cycle incl. mid-stall): all ex_* outputs 0; ex_ctrl_o = bubble. id_stall_o follows its equation.
//  - Bubble: ex_valid_o=0, RegWr=0, MemWr=0, MemtoReg=0, BranchOp=3'b000, MemOp=`MemOpNone, rest of ctrl 0; data/addr fields 0.
//  - load_use = ex_valid_o & ex.MemtoReg & ex.RegWr & (ex_rd_addr_o!=0) & id_valid_i &
//    ((id_rs1_used_i & id_rs1_addr_i==ex_rd_addr_o) | (id_rs2_used_i & id_rs2_addr_i==ex_rd_addr_o)).
//  - id_stall_o = ex_stall_i | (load_use & ~flush_i).
//  - Per edge, priority high->low:
//    1 ex_stall_i: hold every ex_* field; flush_i ignored (source keeps flush_i high until stall drops).
//    2 flush_i: load bubble.
//    3 load_use: load bubble; ID instruction stays in ID and enters EX on a later edge.
//    4 else: capture all id_* inputs; ex_valid_o=id_valid_i. If id_valid_i=0, load bubble (ctrl forced safe).
//  - load_use lasts exactly one cycle, because the bubble clears ex_valid_o. Loads to x0 never stall.
//  - Back-to-back loads with no dependency: no stall.
// CONFIGURATION
//  RISCV_IDEX_PERF_EN defined: adds ports perf_bubble_cnt_o and perf_stall_cnt_o (out, PERF_W).
//    perf_bubble_cnt_o +1 on each edge that loads a bubble due to flush_i or load_use.
//    perf_stall_cnt_o +1 on each edge with ex_stall_i=1.
//    Both counters reset to 0 and wrap modulo 2^PERF_W.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  riscv_define.v holds `CtrlBus (15:0), field offset macros (CTRL_REGWR..CTRL_ALUCTR) and `CTRL_BUBBLE,
//    next to the existing `MemOpNone/`AluctrBus defines.
//  Sub-module riscv_hazard_loaduse (combinational load_use compare), instantiated once; the register stays in the top.
// TESTING
//  1 rst pulse mid-run while ex_valid_o=1, asserted between edges -> all ex_* = 0 immediately (async); first edge after release captures normally.
//  2 add x3,x1,x2 (0x002081B3), id_ctrl_i RegWr=1, ALUctr=0000 -> next edge: ex_valid_o=1, ex_rd_addr_o=3, ex_ctrl_o=id_ctrl_i.
//  3 lw x5,0(x1) then add x6,x5,x0 -> id_stall_o=1 for exactly 1 cycle; EX shows bubble then add; perf_bubble_cnt_o=1.
//  4 lw x0,0(x1) then add x6,x0,x0 -> id_stall_o stays 0; no bubble.
//  5 flush_i=1 with valid sw in ID -> next edge: ex_valid_o=0, MemWr=0, RegWr=0; same test with load_use also true -> bubble, id_stall_o=0.
//  6 ex_stall_i=1 for 3 cycles with flush_i=1 -> ex_* unchanged, id_stall_o=1, perf_stall_cnt_o=3; flush takes effect on the edge after stall drops.

Source files
------------

// File: rtl/riscv_id_ex_reg_pkg.sv
// Shared control-bus layout for the ID/EX stage: field offsets, the safe bubble word
// and a helper that recognises a load from its control bits.
package riscv_id_ex_reg_pkg;

   localparam int CTRL_W           = 16;
   localparam int CTRL_REGWR       = 15;
   localparam int CTRL_BRANCHOP_LSB = 12;
   localparam int CTRL_MEMTOREG    = 11;
   localparam int CTRL_MEMWR       = 10;
   localparam int CTRL_MEMOP_LSB   = 7;
   localparam int CTRL_ALUASRC     = 6;
   localparam int CTRL_ALUBSRC_LSB = 4;
   localparam int CTRL_ALUCTR_LSB  = 0;

   typedef logic [CTRL_W-1:0] ctrl_bus_t;

   localparam logic [2:0] MEM_OP_NONE = 3'b000;

   // Bubble: no register write, no memory access, no branch.
   localparam ctrl_bus_t CTRL_BUBBLE = {1'b0, 3'b000, 1'b0, 1'b0, MEM_OP_NONE,
                                        1'b0, 2'b00, 4'b0000};

   function automatic logic ctrl_is_load(input ctrl_bus_t ctrl);
      return ctrl[CTRL_REGWR] & ctrl[CTRL_MEMTOREG];
   endfunction

endpackage

// File: rtl/riscv_id_ex_reg_hazard.sv
// Load-use hazard compare: a load in EX whose destination is read by the instruction in ID.
module riscv_hazard_loaduse (
   input  logic       ex_valid_i,
   input  logic       ex_is_load_i,
   input  logic [4:0] ex_rd_addr_i,
   input  logic       id_valid_i,
   input  logic       id_rs1_used_i,
   input  logic       id_rs2_used_i,
   input  logic [4:0] id_rs1_addr_i,
   input  logic [4:0] id_rs2_addr_i,
   output logic       load_use_o
);

   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      rs1_hit    = id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i);
      rs2_hit    = id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i);
      // x0 is never written, so a load targeting it cannot create a dependency.
      load_use_o = ex_valid_i & ex_is_load_i & (ex_rd_addr_i != 5'd0) & id_valid_i &
                   (rs1_hit | rs2_hit);
   end

endmodule

// File: rtl/riscv_id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, stall hold and flush.
// Define RISCV_IDEX_PERF_EN to add the bubble/stall performance counters.
module riscv_id_ex_reg
   import riscv_id_ex_reg_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int PERF_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid_i,
   input  logic [XLEN-1:0] id_pc_i,
   input  logic [4:0]      id_rs1_addr_i,
   input  logic [4:0]      id_rs2_addr_i,
   input  logic [4:0]      id_rd_addr_i,
   input  logic            id_rs1_used_i,
   input  logic            id_rs2_used_i,
   input  logic [XLEN-1:0] id_rs1_data_i,
   input  logic [XLEN-1:0] id_rs2_data_i,
   input  logic [XLEN-1:0] id_imm_i,
   input  logic [15:0]     id_ctrl_i,
   input  logic            ex_stall_i,
   input  logic            flush_i,
   output logic            id_stall_o,
   output logic            ex_valid_o,
   output logic [XLEN-1:0] ex_pc_o,
   output logic [XLEN-1:0] ex_rs1_data_o,
   output logic [XLEN-1:0] ex_rs2_data_o,
   output logic [XLEN-1:0] ex_imm_o,
   output logic [4:0]      ex_rs1_addr_o,
   output logic [4:0]      ex_rs2_addr_o,
   output logic [4:0]      ex_rd_addr_o,
   output logic [15:0]     ex_ctrl_o
`ifdef RISCV_IDEX_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_bubble_cnt_o,
   output logic [PERF_W-1:0] perf_stall_cnt_o
`endif
);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] rs1_data_q, rs1_data_d;
   logic [XLEN-1:0] rs2_data_q, rs2_data_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic [4:0]      rs1_addr_q, rs1_addr_d;
   logic [4:0]      rs2_addr_q, rs2_addr_d;
   logic [4:0]      rd_addr_q, rd_addr_d;
   ctrl_bus_t       ctrl_q, ctrl_d;
   logic            load_use;
   logic            load_bubble;

   riscv_hazard_loaduse u_hazard (
      .ex_valid_i    (valid_q),
      .ex_is_load_i  (ctrl_is_load(ctrl_q)),
      .ex_rd_addr_i  (rd_addr_q),
      .id_valid_i    (id_valid_i),
      .id_rs1_used_i (id_rs1_used_i),
      .id_rs2_used_i (id_rs2_used_i),
      .id_rs1_addr_i (id_rs1_addr_i),
      .id_rs2_addr_i (id_rs2_addr_i),
      .load_use_o    (load_use)
   );

   assign id_stall_o = ex_stall_i | (load_use & ~flush_i);

   // Stall wins over flush; an invalid ID slot is also loaded as a safe bubble.
   always_comb begin
      valid_d     = valid_q;
      pc_d        = pc_q;
      rs1_data_d  = rs1_data_q;
      rs2_data_d  = rs2_data_q;
      imm_d       = imm_q;
      rs1_addr_d  = rs1_addr_q;
      rs2_addr_d  = rs2_addr_q;
      rd_addr_d   = rd_addr_q;
      ctrl_d      = ctrl_q;
      load_bubble = 1'b0;
      if (!ex_stall_i) begin
         load_bubble = flush_i | load_use;
         if (load_bubble || !id_valid_i) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            rs1_addr_d = '0;
            rs2_addr_d = '0;
            rd_addr_d  = '0;
            ctrl_d     = CTRL_BUBBLE;
         end else begin
            valid_d    = 1'b1;
            pc_d       = id_pc_i;
            rs1_data_d = id_rs1_data_i;
            rs2_data_d = id_rs2_data_i;
            imm_d      = id_imm_i;
            rs1_addr_d = id_rs1_addr_i;
            rs2_addr_d = id_rs2_addr_i;
            rd_addr_d  = id_rd_addr_i;
            ctrl_d     = id_ctrl_i;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rd_addr_q  <= '0;
         ctrl_q     <= CTRL_BUBBLE;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rd_addr_q  <= rd_addr_d;
         ctrl_q     <= ctrl_d;
      end
   end

   assign ex_valid_o    = valid_q;
   assign ex_pc_o       = pc_q;
   assign ex_rs1_data_o = rs1_data_q;
   assign ex_rs2_data_o = rs2_data_q;
   assign ex_imm_o      = imm_q;
   assign ex_rs1_addr_o = rs1_addr_q;
   assign ex_rs2_addr_o = rs2_addr_q;
   assign ex_rd_addr_o  = rd_addr_q;
   assign ex_ctrl_o     = ctrl_q;

`ifdef RISCV_IDEX_PERF_EN
   logic [PERF_W-1:0] bubble_cnt_q, bubble_cnt_d;
   logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

   // Counters wrap naturally at 2^PERF_W.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q + (load_bubble ? PERF_W'(1) : PERF_W'(0));
      stall_cnt_d  = stall_cnt_q + (ex_stall_i ? PERF_W'(1) : PERF_W'(0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign perf_bubble_cnt_o = bubble_cnt_q;
   assign perf_stall_cnt_o  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_id_ex_reg.sv
// Bench for riscv_id_ex_reg: directed pipeline scenarios checked against literal expectations
// and, on every falling edge, against a per-edge behavioural model of the EX slot.
module tb_riscv_id_ex_reg;
   import riscv_id_ex_reg_pkg::*;

   localparam logic [15:0] ADD_CTRL = 16'h8000;
   localparam logic [15:0] LW_CTRL  = 16'h8910;
   localparam logic [15:0] SW_CTRL  = 16'h0520;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        id_valid_i = 1'b0;
   logic [31:0] id_pc_i = '0;
   logic [4:0]  id_rs1_addr_i = '0;
   logic [4:0]  id_rs2_addr_i = '0;
   logic [4:0]  id_rd_addr_i = '0;
   logic        id_rs1_used_i = 1'b0;
   logic        id_rs2_used_i = 1'b0;
   logic [31:0] id_rs1_data_i = '0;
   logic [31:0] id_rs2_data_i = '0;
   logic [31:0] id_imm_i = '0;
   logic [15:0] id_ctrl_i = '0;
   logic        ex_stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        id_stall_o;
   logic        ex_valid_o;
   logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
   logic [4:0]  ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o;
   logic [15:0] ex_ctrl_o;
`ifdef RISCV_IDEX_PERF_EN
   logic [31:0] perf_bubble_cnt_o, perf_stall_cnt_o;
`endif

   int checkCount = 0;
   int passCount  = 0;
   bit compareEn  = 1'b0;

   riscv_id_ex_reg #(.XLEN(32), .PERF_W(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .id_valid_i    (id_valid_i),
      .id_pc_i       (id_pc_i),
      .id_rs1_addr_i (id_rs1_addr_i),
      .id_rs2_addr_i (id_rs2_addr_i),
      .id_rd_addr_i  (id_rd_addr_i),
      .id_rs1_used_i (id_rs1_used_i),
      .id_rs2_used_i (id_rs2_used_i),
      .id_rs1_data_i (id_rs1_data_i),
      .id_rs2_data_i (id_rs2_data_i),
      .id_imm_i      (id_imm_i),
      .id_ctrl_i     (id_ctrl_i),
      .ex_stall_i    (ex_stall_i),
      .flush_i       (flush_i),
      .id_stall_o    (id_stall_o),
      .ex_valid_o    (ex_valid_o),
      .ex_pc_o       (ex_pc_o),
      .ex_rs1_data_o (ex_rs1_data_o),
      .ex_rs2_data_o (ex_rs2_data_o),
      .ex_imm_o      (ex_imm_o),
      .ex_rs1_addr_o (ex_rs1_addr_o),
      .ex_rs2_addr_o (ex_rs2_addr_o),
      .ex_rd_addr_o  (ex_rd_addr_o),
      .ex_ctrl_o     (ex_ctrl_o)
`ifdef RISCV_IDEX_PERF_EN
      ,
      .perf_bubble_cnt_o (perf_bubble_cnt_o),
      .perf_stall_cnt_o  (perf_stall_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   // Expected contents of the EX slot, one record updated per clock edge.
   typedef struct {
      logic        valid;
      logic [31:0] pc, d1, d2, imm;
      logic [4:0]  a1, a2, rd;
      logic [15:0] ctrl;
   } ex_slot_t;

   ex_slot_t model;
   ex_slot_t bubbleSlot;

   initial begin
      bubbleSlot = '{valid: 1'b0, pc: 32'h0, d1: 32'h0, d2: 32'h0, imm: 32'h0,
                     a1: 5'd0, a2: 5'd0, rd: 5'd0, ctrl: CTRL_BUBBLE};
      model = bubbleSlot;
   end

   // A dependent read of a pending load's destination (never x0) must wait one cycle.
   function automatic logic modelLoadUse();
      logic exIsLoad;
      logic reads;
      exIsLoad = model.valid && model.ctrl[15] && model.ctrl[11] && (model.rd != 5'd0);
      reads    = (id_rs1_used_i && id_rs1_addr_i == model.rd) ||
                 (id_rs2_used_i && id_rs2_addr_i == model.rd);
      return exIsLoad && id_valid_i && reads;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model = bubbleSlot;
      end else if (ex_stall_i) begin
         model = model;
      end else if (flush_i || modelLoadUse() || !id_valid_i) begin
         model = bubbleSlot;
      end else begin
         model = '{valid: 1'b1, pc: id_pc_i, d1: id_rs1_data_i, d2: id_rs2_data_i,
                   imm: id_imm_i, a1: id_rs1_addr_i, a2: id_rs2_addr_i,
                   rd: id_rd_addr_i, ctrl: id_ctrl_i};
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
   endtask

   always @(negedge clk) begin
      if (compareEn) begin
         checkOutput("model ex_valid", 32'(ex_valid_o), 32'(model.valid));
         checkOutput("model ex_pc", ex_pc_o, model.pc);
         checkOutput("model ex_rs1_data", ex_rs1_data_o, model.d1);
         checkOutput("model ex_rs2_data", ex_rs2_data_o, model.d2);
         checkOutput("model ex_imm", ex_imm_o, model.imm);
         checkOutput("model ex_rs1_addr", 32'(ex_rs1_addr_o), 32'(model.a1));
         checkOutput("model ex_rs2_addr", 32'(ex_rs2_addr_o), 32'(model.a2));
         checkOutput("model ex_rd_addr", 32'(ex_rd_addr_o), 32'(model.rd));
         checkOutput("model ex_ctrl", 32'(ex_ctrl_o), 32'(model.ctrl));
         checkOutput("model id_stall", 32'(id_stall_o),
                     32'(ex_stall_i || (modelLoadUse() && !flush_i)));
      end
   end

   // Drives one ID slot; operand data is derived from the PC so every field is distinct.
   task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic used1, input logic used2,
                                input logic [15:0] ctrl, input logic stall, input logic flush);
      id_valid_i    = valid;
      id_pc_i       = pc;
      id_rs1_addr_i = rs1;
      id_rs2_addr_i = rs2;
      id_rd_addr_i  = rd;
      id_rs1_used_i = used1;
      id_rs2_used_i = used2;
      id_rs1_data_i = pc ^ 32'hA5A5_0000;
      id_rs2_data_i = pc ^ 32'h5A5A_0000;
      id_imm_i      = pc + 32'd4;
      id_ctrl_i     = ctrl;
      ex_stall_i    = stall;
      flush_i       = flush;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1 rst = 1'b1;
      #2;
      checkOutput("reset ex_valid", 32'(ex_valid_o), 32'd0);
      checkOutput("reset ex_ctrl", 32'(ex_ctrl_o), 32'(CTRL_BUBBLE));
      #3 rst = 1'b0;
      compareEn = 1'b1;
      step();

      // add x3,x1,x2
      applyStimulus(1, 32'h100, 5'd1, 5'd2, 5'd3, 1, 1, ADD_CTRL, 0, 0);
      step();
      checkOutput("add ex_valid", 32'(ex_valid_o), 32'd1);
      checkOutput("add ex_rd", 32'(ex_rd_addr_o), 32'd3);
      checkOutput("add ex_ctrl", 32'(ex_ctrl_o), 32'h8000);
      checkOutput("add ex_rs1_data", ex_rs1_data_o, 32'hA5A5_0100);

      // Asynchronous reset between edges while EX holds a valid instruction.
      #2 rst = 1'b1;
      #1;
      checkOutput("async rst ex_valid", 32'(ex_valid_o), 32'd0);
      checkOutput("async rst ex_rd", 32'(ex_rd_addr_o), 32'd0);
      checkOutput("async rst ex_pc", ex_pc_o, 32'd0);
      checkOutput("async rst ex_ctrl", 32'(ex_ctrl_o), 32'(CTRL_BUBBLE));
      rst = 1'b0;
      applyStimulus(1, 32'h104, 5'd1, 5'd2, 5'd3, 1, 1, ADD_CTRL, 0, 0);
      step();
      checkOutput("post rst capture", 32'(ex_valid_o), 32'd1);

      // lw x5,0(x1) then add x6,x5,x0
      applyStimulus(1, 32'h200, 5'd1, 5'd0, 5'd5, 1, 0, LW_CTRL, 0, 0);
      step();
      applyStimulus(1, 32'h204, 5'd5, 5'd0, 5'd6, 1, 1, ADD_CTRL, 0, 0);
      #1 checkOutput("loaduse id_stall", 32'(id_stall_o), 32'd1);
      step();
      checkOutput("loaduse bubble valid", 32'(ex_valid_o), 32'd0);
      checkOutput("loaduse stall drops", 32'(id_stall_o), 32'd0);
      step();
      checkOutput("loaduse add valid", 32'(ex_valid_o), 32'd1);
      checkOutput("loaduse add rd", 32'(ex_rd_addr_o), 32'd6);
`ifdef RISCV_IDEX_PERF_EN
      checkOutput("perf bubble after loaduse", perf_bubble_cnt_o, 32'd1);
`endif

      // lw x0,0(x1) then add x6,x0,x0: no stall
      applyStimulus(1, 32'h300, 5'd1, 5'd0, 5'd0, 1, 0, LW_CTRL, 0, 0);
      step();
      applyStimulus(1, 32'h304, 5'd0, 5'd0, 5'd6, 1, 1, ADD_CTRL, 0, 0);
      #1 checkOutput("x0 load id_stall", 32'(id_stall_o), 32'd0);
      step();
      checkOutput("x0 load no bubble", 32'(ex_valid_o), 32'd1);

      // Back-to-back independent loads.
      applyStimulus(1, 32'h320, 5'd1, 5'd0, 5'd5, 1, 0, LW_CTRL, 0, 0);
      step();
      applyStimulus(1, 32'h324, 5'd2, 5'd0, 5'd6, 1, 0, LW_CTRL, 0, 0);
      #1 checkOutput("lw lw id_stall", 32'(id_stall_o), 32'd0);
      step();
      checkOutput("lw lw rd", 32'(ex_rd_addr_o), 32'd6);

      // Flush a valid sw in ID.
      applyStimulus(1, 32'h400, 5'd2, 5'd3, 5'd0, 1, 1, SW_CTRL, 0, 1);
      step();
      checkOutput("flush valid", 32'(ex_valid_o), 32'd0);
      checkOutput("flush memwr", 32'(ex_ctrl_o[10]), 32'd0);
      checkOutput("flush regwr", 32'(ex_ctrl_o[15]), 32'd0);

      // Flush while a load-use is also pending.
      applyStimulus(1, 32'h500, 5'd1, 5'd0, 5'd5, 1, 0, LW_CTRL, 0, 0);
      step();
      applyStimulus(1, 32'h504, 5'd2, 5'd5, 5'd0, 1, 1, SW_CTRL, 0, 1);
      #1 checkOutput("flush+lu id_stall", 32'(id_stall_o), 32'd0);
      step();
      checkOutput("flush+lu valid", 32'(ex_valid_o), 32'd0);

      // Stall for 3 cycles with flush held high, then flush lands.
      applyStimulus(1, 32'h600, 5'd1, 5'd0, 5'd7, 1, 0, LW_CTRL, 0, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 32'h604, 5'd7, 5'd0, 5'd6, 1, 1, ADD_CTRL, 1, 1);
         #1 checkOutput("stall id_stall", 32'(id_stall_o), 32'd1);
         step();
         checkOutput("stall hold rd", 32'(ex_rd_addr_o), 32'd7);
         checkOutput("stall hold pc", ex_pc_o, 32'h600);
      end
`ifdef RISCV_IDEX_PERF_EN
      checkOutput("perf stall count", perf_stall_cnt_o, 32'd3);
`endif
      applyStimulus(1, 32'h604, 5'd7, 5'd0, 5'd6, 1, 1, ADD_CTRL, 0, 1);
      step();
      checkOutput("flush after stall", 32'(ex_valid_o), 32'd0);
`ifdef RISCV_IDEX_PERF_EN
      checkOutput("perf bubble total", perf_bubble_cnt_o, 32'd4);
`endif

      // Invalid ID slot loads a bubble even with live-looking fields.
      applyStimulus(0, 32'h700, 5'd1, 5'd2, 5'd9, 1, 1, ADD_CTRL, 0, 0);
      step();
      checkOutput("invalid id bubble ctrl", 32'(ex_ctrl_o), 32'(CTRL_BUBBLE));
      applyStimulus(1, 32'h704, 5'd4, 5'd8, 5'd9, 1, 1, ADD_CTRL, 0, 0);
      step();
      step();
      compareEn = 1'b0;
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
